bitty_fetch_unit: RTL and testbench

// Instruction fetch/sequencer that sits directly upstream of the bitty control unit.

---
 rtl/bitty_fetch_unit.sv | 135 +++++++++++++
 tb/tb_bitty_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/sequencer for the bitty control unit: loadable program memory,
// PC, and a FETCH/ISSUE handshake on the control unit's done pulse with a timeout.
module bitty_fetch_unit #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W:0]     run_len,
   input  logic                prog_we,
   input  logic [ADDR_W-1:0]   prog_addr,
   input  logic [INSTR_W-1:0]  prog_data,
   input  logic                done,
   output logic [INSTR_W-1:0]  instruction,
   output logic                en_i,
   output logic                en_s,
   output logic                en_c,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W:0]     instr_count,
   output logic                busy,
   output logic                halted,
   output logic                error
);

   localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     run_len_q, run_len_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 error_q, error_d;
   logic [CNT_W-1:0]     cnt_inc_c;
   logic                 mem_we_c;
   logic [INSTR_W-1:0]   mem_q [MEM_DEPTH];

   assign cnt_inc_c = cnt_q + CNT_W'(1);
   // Loading is only safe while no instruction is in flight
   assign mem_we_c  = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

   // Next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      run_len_d = run_len_q;
      instr_d   = instr_q;
      tmo_d     = tmo_q;
      error_d   = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               run_len_d = run_len;
               pc_d      = '0;
               cnt_d     = '0;
               error_d   = 1'b0;
               state_d   = (run_len != '0) ? S_FETCH : S_HALT;
            end
         end
         S_FETCH: begin
            instr_d = mem_q[pc_q];
            tmo_d   = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (done) begin
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == run_len_q) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = S_HALT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_HALT: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         run_len_q <= '0;
         instr_q   <= '0;
         tmo_q     <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         run_len_q <= run_len_d;
         instr_q   <= instr_d;
         tmo_q     <= tmo_d;
         error_q   <= error_d;
      end
   end

   // Program memory survives reset
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[prog_addr] <= prog_data;
   end

   assign instruction = instr_q;
   assign en_i        = (state_q == S_ISSUE);
   assign en_s        = (state_q == S_ISSUE);
   assign en_c        = (state_q == S_ISSUE);
   assign pc          = pc_q;
   assign instr_count = cnt_q;
   assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
   assign halted      = (state_q == S_HALT);
   assign error       = error_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: the bench plays the control unit and
// predicts the ISSUE sequence from the program-memory image and done latencies.
module tb_bitty_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, prog_we, done;
   logic [8:0]  run_len;
   logic [7:0]  prog_addr;
   logic [15:0] prog_data;

   logic [15:0] m_instr, s_instr;
   logic        m_eni, m_ens, m_enc, s_eni, s_ens, s_enc;
   logic [7:0]  m_pc;
   logic [1:0]  s_pc;
   logic [8:0]  m_cnt;
   logic [2:0]  s_cnt;
   logic        m_busy, m_halted, m_error, s_busy, s_halted, s_error;

   bitty_fetch_unit u_main (
      .clk(clk), .reset(reset), .start(start), .run_len(run_len),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .done(done),
      .instruction(m_instr), .en_i(m_eni), .en_s(m_ens), .en_c(m_enc), .pc(m_pc),
      .instr_count(m_cnt), .busy(m_busy), .halted(m_halted), .error(m_error));

   bitty_fetch_unit #(.ADDR_W(2)) u_small (
      .clk(clk), .reset(reset), .start(start), .run_len(run_len[2:0]),
      .prog_we(prog_we), .prog_addr(prog_addr[1:0]), .prog_data(prog_data), .done(done),
      .instruction(s_instr), .en_i(s_eni), .en_s(s_ens), .en_c(s_enc), .pc(s_pc),
      .instr_count(s_cnt), .busy(s_busy), .halted(s_halted), .error(s_error));

   bit          sel_small = 1'b0;
   logic [15:0] o_instr;
   logic        o_en_any, o_en_all, o_busy, o_halted, o_error;
   logic [7:0]  o_pc;
   logic [8:0]  o_cnt;

   always_comb begin
      if (sel_small) begin
         o_instr  = s_instr;
         o_en_any = s_eni | s_ens | s_enc;
         o_en_all = s_eni & s_ens & s_enc;
         o_pc     = {6'd0, s_pc};
         o_cnt    = {6'd0, s_cnt};
         o_busy   = s_busy;
         o_halted = s_halted;
         o_error  = s_error;
      end else begin
         o_instr  = m_instr;
         o_en_any = m_eni | m_ens | m_enc;
         o_en_all = m_eni & m_ens & m_enc;
         o_pc     = m_pc;
         o_cnt    = m_cnt;
         o_busy   = m_busy;
         o_halted = m_halted;
         o_error  = m_error;
      end
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [15:0] mem_m [256];
   logic [15:0] mem_s [4];

   function automatic int unsigned depth();
      return sel_small ? 4 : 256;
   endfunction

   function automatic logic [15:0] model_mem(input int unsigned k);
      if (sel_small) return mem_s[k % 4];
      return mem_m[k % 256];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic write_mem(input int unsigned a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = 8'(a); prog_data = d;
      tick();
      prog_we = 1'b0;
      mem_m[a % 256] = d;
      mem_s[a % 4]   = d;
   endtask

   task automatic apply_reset();
      reset = 1'b0; start = 1'b0; prog_we = 1'b0; done = 1'b0;
      run_len = '0; prog_addr = '0; prog_data = '0;
      tick(); tick();
   endtask

   // Runs n instructions; each ISSUE is answered with done after lat cycles (4 or random)
   task automatic run_prog(input int unsigned n, input bit rand_lat, input bit we_mid,
                           input bit we_start, input string tag);
      int unsigned cyc, exp_c, lat, budget;
      logic [15:0] held;
      logic [7:0]  exp_pc;
      run_len = 9'(n); start = 1'b1;
      if (we_start) begin
         prog_we = 1'b1; prog_addr = '0; prog_data = 16'($urandom);
         mem_m[0] = prog_data; mem_s[0] = prog_data;
      end
      cyc = 0; exp_c = 2;
      for (int k = 0; k < int'(n); k++) begin
         lat = rand_lat ? $urandom_range(0, 8) : 4;
         budget = 0;
         while (!o_en_any && budget < 20) begin
            done = 1'($urandom);
            tick(); prog_we = 1'b0; cyc++; budget++;
         end
         n_cmp++;
         if (!o_en_any) begin
            n_bad++;
            $display("FAIL %s issue wait k=%0d: got no enable want enable", tag, k);
            done = 1'b0; start = 1'b0; prog_we = 1'b0;
            return;
         end
         exp_pc = 8'(k % depth());
         n_cmp++;
         if (cyc !== exp_c) begin
            n_bad++; $display("FAIL %s issue cycle k=%0d: got %0d want %0d", tag, k, cyc, exp_c);
         end
         n_cmp++;
         if ({o_en_all, o_busy, o_halted} !== 3'b110) begin
            n_bad++; $display("FAIL %s issue flags k=%0d: got %b want 110", tag, k, {o_en_all, o_busy, o_halted});
         end
         n_cmp++;
         if (o_pc !== exp_pc) begin
            n_bad++; $display("FAIL %s pc k=%0d: got %0d want %0d", tag, k, o_pc, exp_pc);
         end
         n_cmp++;
         if (o_instr !== model_mem(k)) begin
            n_bad++; $display("FAIL %s instr k=%0d: got %h want %h", tag, k, o_instr, model_mem(k));
         end
         n_cmp++;
         if (o_cnt !== 9'(k)) begin
            n_bad++; $display("FAIL %s count k=%0d: got %0d want %0d", tag, k, o_cnt, k);
         end
         n_cmp++;
         if (o_error !== 1'b0) begin
            n_bad++; $display("FAIL %s error k=%0d: got %b want 0", tag, k, o_error);
         end
         held = o_instr;
         if (we_mid && k == 0) begin
            prog_we = 1'b1; prog_addr = 8'd1; prog_data = ~model_mem(1);
         end
         done = (lat == 0);
         for (int j = 1; j <= int'(lat); j++) begin
            tick(); prog_we = 1'b0; cyc++;
            n_cmp++;
            if ({o_en_all, o_instr, o_pc} !== {1'b1, held, exp_pc}) begin
               n_bad++;
               $display("FAIL %s stable k=%0d j=%0d: got en=%b %h pc=%0d want en=1 %h pc=%0d",
                        tag, k, j, o_en_all, o_instr, o_pc, held, exp_pc);
            end
            done = (j == int'(lat));
         end
         tick(); prog_we = 1'b0; done = 1'b0; cyc++;
         exp_c = exp_c + lat + 2;
      end
      n_cmp++;
      if ({o_halted, o_busy, o_en_any, o_error} !== 4'b1000) begin
         n_bad++; $display("FAIL %s end flags: got %b want 1000", tag, {o_halted, o_busy, o_en_any, o_error});
      end
      n_cmp++;
      if (cyc !== exp_c - 1) begin
         n_bad++; $display("FAIL %s halt cycle: got %0d want %0d", tag, cyc, exp_c - 1);
      end
      n_cmp++;
      if (o_cnt !== 9'(n)) begin
         n_bad++; $display("FAIL %s final count: got %0d want %0d", tag, o_cnt, n);
      end
      n_cmp++;
      if (o_pc !== 8'((n - 1) % depth())) begin
         n_bad++; $display("FAIL %s final pc: got %0d want %0d", tag, o_pc, (n - 1) % depth());
      end
      start = 1'b0;
      tick();
      n_cmp++;
      if ({o_halted, o_busy} !== 2'b00) begin
         n_bad++; $display("FAIL %s back to idle: got %b want 00", tag, {o_halted, o_busy});
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({o_en_any, o_busy, o_halted, o_error, o_pc, o_cnt, o_instr} !== '0) begin
         n_bad++;
         $display("FAIL reset outputs: got en=%b busy=%b halt=%b err=%b pc=%0d cnt=%0d instr=%h want all 0",
                  o_en_any, o_busy, o_halted, o_error, o_pc, o_cnt, o_instr);
      end
      reset = 1'b1;
   endtask

   task automatic load_basic();
      write_mem(0, 16'h2004); write_mem(1, 16'h4408); write_mem(2, 16'h600C);
   endtask

   task automatic test_basic();
      load_basic();
      run_prog(3, 1'b0, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_run_zero();
      run_len = '0; start = 1'b1;
      tick();
      n_cmp++;
      if ({o_halted, o_busy, o_en_any, o_cnt} !== {3'b100, 9'd0}) begin
         n_bad++; $display("FAIL run_zero halt: got halt=%b busy=%b en=%b cnt=%0d want 1 0 0 0", o_halted, o_busy, o_en_any, o_cnt);
      end
      tick();
      n_cmp++;
      if ({o_halted, o_en_any} !== 2'b10) begin
         n_bad++; $display("FAIL run_zero hold: got %b want 10", {o_halted, o_en_any});
      end
      start = 1'b0;
      tick();
      n_cmp++;
      if (o_halted !== 1'b0) begin
         n_bad++; $display("FAIL run_zero idle: got %b want 0", o_halted);
      end
   endtask

   task automatic test_timeout();
      int unsigned cyc, en_cyc;
      run_len = 9'd2; start = 1'b1; done = 1'b0;
      cyc = 0; en_cyc = 0;
      while (!o_halted && cyc < 60) begin
         tick(); cyc++;
         if (o_en_any) en_cyc++;
      end
      n_cmp++;
      if (cyc !== 17) begin
         n_bad++; $display("FAIL timeout halt cycle: got %0d want 17", cyc);
      end
      n_cmp++;
      if (en_cyc !== 15) begin
         n_bad++; $display("FAIL timeout issue cycles: got %0d want 15", en_cyc);
      end
      n_cmp++;
      if ({o_error, o_halted, o_cnt, o_pc} !== {2'b11, 9'd0, 8'd0}) begin
         n_bad++; $display("FAIL timeout flags: got err=%b halt=%b cnt=%0d pc=%0d want 1 1 0 0", o_error, o_halted, o_cnt, o_pc);
      end
      start = 1'b0;
      tick();
      n_cmp++;
      if (o_error !== 1'b1) begin
         n_bad++; $display("FAIL timeout sticky: got %b want 1", o_error);
      end
      run_prog(2, 1'b0, 1'b0, 1'b0, "after_timeout");
   endtask

   task automatic test_mid_reset();
      int unsigned cyc, il, seen;
      load_basic();
      run_len = 9'd3; start = 1'b1; done = 1'b0;
      cyc = 0; il = 0; seen = 0;
      while (seen < 2 && cyc < 40) begin
         tick(); cyc++;
         if (o_en_any) il++; else il = 0;
         if (il == 1) seen++;
         done = (il == 5);
      end
      n_cmp++;
      if (seen !== 2 || o_pc !== 8'd1) begin
         n_bad++; $display("FAIL mid_reset reach 2nd issue: got seen=%0d pc=%0d want 2 1", seen, o_pc);
      end
      reset = 1'b0; start = 1'b0; done = 1'b0;
      tick();
      n_cmp++;
      if ({o_en_any, o_busy, o_halted, o_error, o_pc, o_cnt, o_instr} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset outputs: got en=%b busy=%b halt=%b err=%b pc=%0d cnt=%0d instr=%h want all 0",
                  o_en_any, o_busy, o_halted, o_error, o_pc, o_cnt, o_instr);
      end
      reset = 1'b1;
      run_prog(1, 1'b0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_prog_guard();
      load_basic();
      run_prog(3, 1'b0, 1'b1, 1'b0, "we_in_issue");
      run_len = '0; start = 1'b1;
      tick();
      write_mem(1, 16'hBEEF);
      start = 1'b0;
      tick();
      run_prog(3, 1'b0, 1'b0, 1'b0, "we_in_halt");
   endtask

   task automatic test_random();
      int unsigned n;
      bit ws;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 12);
         for (int a = 0; a < int'(n); a++) write_mem(a, 16'($urandom));
         ws = 1'($urandom);
         run_prog(n, 1'b1, 1'b0, ws, "random");
      end
   endtask

   task automatic test_full_depth();
      for (int a = 0; a < 256; a++) write_mem(a, 16'($urandom));
      run_prog(256, 1'b1, 1'b0, 1'b0, "full_depth");
      run_prog(258, 1'b1, 1'b0, 1'b0, "wrap_main");
   endtask

   task automatic test_wrap_small();
      sel_small = 1'b1;
      apply_reset();
      reset = 1'b1;
      for (int a = 0; a < 4; a++) write_mem(a, 16'($urandom));
      run_prog(5, 1'b0, 1'b0, 1'b0, "wrap_small");
      run_prog(4, 1'b1, 1'b0, 1'b0, "small_depth");
      run_prog(7, 1'b1, 1'b0, 1'b0, "small_long");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; start = 1'b0; prog_we = 1'b0; done = 1'b0;
      run_len = '0; prog_addr = '0; prog_data = '0;
      test_reset();
      test_basic();
      test_run_zero();
      test_timeout();
      test_mid_reset();
      test_prog_guard();
      test_random();
      test_full_depth();
      test_wrap_small();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
